wb_b3_ram_slave: RTL and testbench
==================================

Name: wb_b3_ram_slave

Overview:
- On-chip single-port SRAM exposed as a WISHBONE B3 slave. It sits directly downstream of the CPU instruction/data WISHBONE masters, behind the system interconnect.
- Serves classic single cycles with one wait state.
- Serves B3 incrementing bursts (linear and wrap-4/8/16) at one beat per clock after the first beat, so the CPU's cache line refills run at full rate.
- Out-of-range word accesses terminate with an error instead of an acknowledge.

Parameters:
- aw, 12, word-address width of the RAM array (depth 2^aw words).
- mem_words, 4096, implemented words. Must be ≤ 2^aw. Word index ≥ mem_words returns an error.
- dw, 32, data width. Fixed at 32; wb_sel_i is 4 bits.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects; bit n selects byte lane [8n+7:8n].
- wb_adr_i  in  32  byte address. Bits [aw+1:2] are the word index; all other bits are ignored because the interconnect decodes them.
- wb_dat_i  in  32  write data.
- wb_cti_i  in  3  cycle type identifier.
- wb_bte_i  in  2  burst type extension.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry; tied to 0.

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, ack_q=0, err_q=0, wb_dat_o=0, predicted address=0. RAM contents are not reset.
- Request: req = wb_cyc_i & wb_stb_i.
- Output gating: wb_ack_o = ack_q & req and wb_err_o = err_q & req. A terminating strobe is never given while cyc or stb is low.
- Cycle types:
  - cti 000, 001, 111 outside a burst are classic cycles.
  - cti 010 is an incrementing burst.
  - cti 011–110 (reserved) are treated as classic.
- State IDLE:
  - On req, latch the word index and sample the RAM at wb_adr_i.
  - If the index ≥ mem_words, set err_q for the next cycle. Go to WAIT_TERM.
  - Otherwise set ack_q for the next cycle. Go to WAIT_TERM if classic, or BURST if cti=010.
  - First-beat latency is therefore 1 wait state: ack/err is asserted in the 2nd cycle of req.
- State WAIT_TERM (classic termination cycle):
  - The termination is a one-cycle pulse.
  - ack_q/err_q clear next cycle and the state returns to IDLE.
  - Back-to-back classic cycles therefore take 2 clocks each.
- State BURST:
  - During each beat with wb_ack_o=1 and wb_cti_i=010, the RAM is read at the predicted next address and ack_q stays 1.
  - The beat with wb_cti_i=111 and wb_ack_o=1 is the last beat: ack_q clears and the state goes to IDLE.
  - Master wait state (stb low while cyc high): wb_ack_o is low, the state is held, and the prediction is held. The beat completes when stb returns, with the held data.
  - Mispredict: if wb_adr_i[aw+1:2] ≠ predicted index while req, deassert ack_q and restart as an IDLE access with 1 wait state.
  - If a predicted index reaches ≥ mem_words, the next beat terminates with wb_err_o and the burst ends (go to WAIT_TERM).
- Next-address rule: the index increments by 1 word within a wrap window selected by wb_bte_i.
  - 00 linear: increment modulo 2^aw.
  - 01 wrap-4: index[1:0] increments mod 4; the upper bits are held.
  - 10 wrap-8: index[2:0] increments mod 8.
  - 11 wrap-16: index[3:0] increments mod 16.
- Writes:
  - The RAM is written in a cycle where wb_ack_o & wb_we_i, at wb_adr_i[aw+1:2].
  - Only lanes with wb_sel_i=1 are written. wb_sel_i=0000 still acks and writes nothing.
  - No write occurs on an error termination.
  - Read-during-write of the same word returns the old data.
- Read data: wb_dat_o is registered and is valid in every cycle where wb_ack_o=1. It holds its value otherwise.
- wb_cyc_i dropping in any state returns the state to IDLE next cycle, with ack_q=0 and err_q=0.
- Reset asserted mid-burst aborts immediately. No partial write occurs after reset assertion.
- wb_rty_o is constant 0.

Test Plan:
- Reset: hold rst_n_i=0 while driving req -> wb_ack_o, wb_err_o and wb_rty_o stay 0 and wb_dat_o=0. Release reset -> the first classic read acks in the 2nd cycle.
- Classic write/read:
  - Write 0xDEADBEEF to 0x100 with sel=1111, then write 0x000000AA with sel=0001 -> each acks after 1 wait, one-cycle pulse.
  - Read 0x100 -> 0xDEADBEAA.
- Wrap-4 burst read: preload words 0x40–0x43 with 0xA0–0xA3. Start at 0x108 with cti=010, bte=01, last beat cti=111 -> beats return 0xA2, 0xA3, 0xA0, 0xA1. Acks occur on 4 consecutive cycles after 1 initial wait, then ack=0.
- Master wait mid-burst: during a linear burst, drop stb for 2 cycles after beat 2 -> ack is low during those cycles, beat 3 returns the correct word when stb returns, and no beat is skipped or duplicated.
- Mispredict: during a burst, present a non-sequential address -> ack drops for 1 cycle, then the data at the new address is acked.
- Error and abort:
  - Classic access to word mem_words -> wb_err_o pulses 1 cycle, no ack, RAM unchanged.
  - Drop cyc mid-burst, then assert rst_n_i=0 mid-burst -> ack=0 immediately and no further writes.

Source files
------------

// File: rtl/wb_b3_ram_slave_if.sv
// WISHBONE B3 classic/burst bus bundle between one master and the RAM slave.
// Data and address are fixed at 32 bits; sel carries one bit per byte lane.
interface wb_b3_ram_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, sel, adr, wdat, cti, bte,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, sel, adr, wdat, cti, bte,
    output rdat, ack, err, rty
  );
endinterface

// File: rtl/wb_b3_ram_slave.sv
// Single-port on-chip SRAM as a WISHBONE B3 slave: classic cycles with one wait
// state, incrementing (linear/wrap) bursts at one beat per clock, error on out-of-range words.
module wb_b3_ram_slave #(
  parameter int aw        = 12,
  parameter int mem_words = 4096,
  parameter int dw        = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  wb_b3_ram_slave_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT_TERM, BURST} state_t;

  localparam logic [aw:0] limit = (aw+1)'(mem_words);

  state_t          state_q, state_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic [aw-1:0]   pred_q, pred_d;
  logic [aw-1:0]   idx_in, rd_idx, nxt_idx;
  logic            req, miss, start, rd_en, wr_en;
  logic [dw-1:0]   dat_q;
  logic [dw-1:0]   mem [mem_words];
  logic            unused_adr;

  function automatic logic in_range(input logic [aw-1:0] i);
    return {1'b0, i} < limit;
  endfunction

  // Next word inside the wrap window chosen by bte; bits above the window are held.
  function automatic logic [aw-1:0] next_idx(input logic [aw-1:0] i, input logic [1:0] bte);
    logic [aw-1:0] inc;
    inc = i + aw'(1);
    case (bte)
      2'b01:   return {i[aw-1:2], inc[1:0]};
      2'b10:   return {i[aw-1:3], inc[2:0]};
      2'b11:   return {i[aw-1:4], inc[3:0]};
      default: return inc;
    endcase
  endfunction

  assign idx_in     = bus.adr[aw+1:2];
  assign unused_adr = ^{bus.adr[31:aw+2], bus.adr[1:0]};
  assign req        = bus.cyc & bus.stb;
  assign nxt_idx    = next_idx(pred_q, bus.bte);

  // A registered ack in BURST belongs to the predicted word only; a different
  // address must never be acknowledged with the prefetched data.
  assign miss    = (state_q == BURST) && (idx_in != pred_q);
  assign bus.ack = ack_q & req & ~miss;
  assign bus.err = err_q & req;
  assign bus.rty = 1'b0;
  assign bus.rdat = dat_q;

  assign wr_en = bus.ack & bus.we & in_range(idx_in);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    pred_d  = pred_q;
    rd_en   = 1'b0;
    rd_idx  = idx_in;
    start   = 1'b0;
    if (!bus.cyc) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: start = req;
        WAIT_TERM: begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
        BURST: begin
          if (req) begin
            if (miss) begin
              start = 1'b1;
            end else if (bus.cti == 3'b010) begin
              pred_d = nxt_idx;
              if (in_range(nxt_idx)) begin
                rd_en  = 1'b1;
                rd_idx = nxt_idx;
              end else begin
                ack_d   = 1'b0;
                err_d   = 1'b1;
                state_d = WAIT_TERM;
              end
            end else begin
              ack_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // A fresh access always costs one wait state, whether from IDLE or after a mispredict.
      if (start) begin
        pred_d = idx_in;
        rd_en  = in_range(idx_in);
        ack_d  = in_range(idx_in);
        err_d  = ~in_range(idx_in);
        if (!in_range(idx_in))        state_d = WAIT_TERM;
        else if (bus.cti == 3'b010)   state_d = BURST;
        else                          state_d = WAIT_TERM;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pred_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pred_q  <= pred_d;
      if (rd_en) dat_q <= mem[rd_idx];
    end
  end

  // NOTE: the array has no reset so it maps onto SRAM; writes are safe because ack_q is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.sel[l]) mem[idx_in][8*l +: 8] <= bus.wdat[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_b3_ram_slave.sv
// Randomized self-checking bench for wb_b3_ram_slave against a word-array model
// of the RAM and the B3 address sequencing rules.
module tb_wb_b3_ram_slave;
  localparam int AW = 12;
  localparam int MW = 3072;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  wb_b3_ram_slave_if bus ();

  wb_b3_ram_slave #(.aw(AW), .mem_words(MW), .dw(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [MW];
  bit          known [MW];

  task automatic idle_bus();
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.sel = 0;
    bus.adr = 0; bus.wdat = 0; bus.cti = 0; bus.bte = 0;
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    logic [31:0] a;
    a = $urandom();
    a[AW+1:2] = idx[AW-1:0];
    return a;
  endfunction

  // Word that follows idx inside an aligned window of 4/8/16 words (or the whole array).
  function automatic int next_model(input int idx, input bit [1:0] bte);
    int win;
    win = (bte == 2'b00) ? (1 << AW) : (2 << bte);
    return (idx / win) * win + ((idx % win) + 1) % win;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++) if (s[l]) model[idx][8*l +: 8] = d[8*l +: 8];
    if (s == 4'hf) known[idx] = 1;
  endtask

  task automatic wait_term(output logic a, output logic e, output int n);
    a = 0; e = 0; n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (bus.ack === 1'b1 || bus.err === 1'b1) begin
        a = bus.ack; e = bus.err; n = c;
        return;
      end
    end
  endtask

  task automatic classic(input bit we, input int idx, input logic [3:0] sel,
                         input logic [31:0] d, input bit exp_err, input string name);
    logic a, e;
    int n;
    @(posedge clk_i); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = we; bus.sel = sel; bus.wdat = d;
    bus.adr = addr_of(idx); bus.bte = 2'($urandom());
    case ($urandom_range(0, 4))
      0: bus.cti = 3'b000;
      1: bus.cti = 3'b001;
      2: bus.cti = 3'b111;
      3: bus.cti = 3'b011;
      default: bus.cti = 3'b110;
    endcase
    wait_term(a, e, n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL %s latency got %0d cycles expected 2", name, n);
    end
    checks++;
    if ({a, e} !== (exp_err ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL %s termination ack/err got %b%b expected %b", name, a, e,
                         exp_err ? 2'b01 : 2'b10);
    end
    if (a === 1'b1 && !we && known[idx]) begin
      checks++;
      if (bus.rdat !== model[idx]) begin
        errors++; $display("FAIL %s rdata got %h expected %h", name, bus.rdat, model[idx]);
      end
    end
    if (a === 1'b1 && we) model_write(idx, d, sel);
    @(negedge clk_i);
    checks++;
    if ((bus.ack | bus.err) !== 1'b0) begin
      errors++; $display("FAIL %s pulse ack/err got %b%b expected 00", name, bus.ack, bus.err);
    end
    @(posedge clk_i); #1;
    idle_bus();
  endtask

  // Master-driven burst; gap_after inserts a 2-cycle stb gap after that beat,
  // mp_at replaces that beat's address with a non-sequential one.
  task automatic burst(input bit we, input int start, input int nbeats, input bit [1:0] bte,
                       input int gap_after, input int mp_at, input string name);
    int idx, n, exp_n;
    logic a, e;
    bit exp_err;
    logic [31:0] d;
    logic [3:0] s;
    idx = start;
    @(posedge clk_i); #1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == mp_at) begin
        int p;
        p = idx;
        idx = $urandom_range(0, 200);
        if (idx == p) idx = (idx + 7) % 200;
      end
      d = $urandom();
      s = (we && idx < MW && known[idx]) ? 4'($urandom()) : 4'hf;
      bus.cyc = 1; bus.stb = 1; bus.we = we; bus.sel = s; bus.wdat = d; bus.bte = bte;
      bus.adr = addr_of(idx);
      bus.cti = (b == nbeats - 1) ? 3'b111 : 3'b010;
      exp_n   = (b == 0 || b == mp_at) ? 2 : 1;
      exp_err = (idx >= MW);
      wait_term(a, e, n);
      checks++;
      if (n != exp_n) begin
        errors++; $display("FAIL %s beat %0d latency got %0d expected %0d", name, b, n, exp_n);
      end
      checks++;
      if ({a, e} !== (exp_err ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL %s beat %0d ack/err got %b%b expected %b", name, b, a, e,
                           exp_err ? 2'b01 : 2'b10);
      end
      if (a === 1'b1) begin
        if (we) model_write(idx, d, s);
        else if (known[idx]) begin
          checks++;
          if (bus.rdat !== model[idx]) begin
            errors++; $display("FAIL %s beat %0d rdata got %h expected %h", name, b, bus.rdat, model[idx]);
          end
        end
      end
      @(posedge clk_i); #1;
      if (exp_err) break;
      if (b == gap_after) begin
        bus.stb = 0;
        repeat (2) begin
          @(negedge clk_i);
          checks++;
          if (bus.ack !== 1'b0) begin
            errors++; $display("FAIL %s gap ack got %b expected 0", name, bus.ack);
          end
        end
        @(posedge clk_i); #1;
      end
      idx = next_model(idx, bte);
    end
    bus.cti = 3'b000; bus.we = 0;
    @(negedge clk_i);
    checks++;
    if ((bus.ack | bus.err) !== 1'b0) begin
      errors++; $display("FAIL %s after-last ack/err got %b%b expected 00", name, bus.ack, bus.err);
    end
    @(posedge clk_i); #1;
    idle_bus();
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    bus.cyc = 1; bus.stb = 1; bus.adr = addr_of(5); bus.cti = 3'b000;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if ({bus.ack, bus.err, bus.rty} !== 3'b000) begin
        errors++; $display("FAIL reset ack/err/rty got %b%b%b expected 000", bus.ack, bus.err, bus.rty);
      end
      checks++;
      if (bus.rdat !== 32'h0) begin
        errors++; $display("FAIL reset rdata got %h expected 0", bus.rdat);
      end
    end
    idle_bus();
    @(posedge clk_i); #1;
    rst_n_i = 1;
    classic(0, 5, 4'hf, 0, 0, "first_read");
  endtask

  task automatic test_classic();
    classic(1, 32'h100 >> 2, 4'b1111, 32'hDEADBEEF, 0, "wr_full");
    classic(1, 32'h100 >> 2, 4'b0001, 32'h000000AA, 0, "wr_lane0");
    classic(0, 32'h100 >> 2, 4'b0000, 0, 0, "rd_merged");
    checks++;
    if (model[32'h40] !== 32'hDEADBEAA) begin
      errors++; $display("FAIL merged model got %h expected deadbeaa", model[32'h40]);
    end
    classic(1, 32'h100 >> 2, 4'b0000, 32'h12345678, 0, "wr_nosel");
    classic(0, 32'h100 >> 2, 4'b1111, 0, 0, "rd_nosel");
  endtask

  task automatic test_wrap4();
    for (int i = 0; i < 4; i++) classic(1, 32'h40 + i, 4'hf, 32'hA0 + i, 0, "wrap_preload");
    burst(0, 32'h108 >> 2, 4, 2'b01, -1, -1, "wrap4");
  endtask

  task automatic test_master_wait();
    burst(0, 10, 6, 2'b00, 1, -1, "wait_lin_rd");
    burst(1, 40, 5, 2'b10, 2, -1, "wait_wrap8_wr");
    burst(0, 40, 8, 2'b10, -1, -1, "wrap8_readback");
  endtask

  task automatic test_mispredict();
    burst(0, 20, 6, 2'b00, -1, 3, "mispredict_rd");
    burst(1, 64, 6, 2'b11, -1, 2, "mispredict_wr");
  endtask

  task automatic test_random();
    for (int k = 0; k < 14; k++) begin
      int nb, gap, mp;
      nb  = $urandom_range(1, 8);
      gap = ($urandom_range(0, 2) == 0 && nb > 1) ? $urandom_range(0, nb - 2) : -1;
      mp  = ($urandom_range(0, 2) == 0 && nb > 1) ? $urandom_range(1, nb - 1) : -1;
      burst(1'($urandom()), $urandom_range(0, 200), nb, 2'($urandom()), gap, mp, "rand_burst");
      classic(1'($urandom()), $urandom_range(0, 255), 4'($urandom()), $urandom(), 0, "rand_classic");
    end
  endtask

  task automatic test_error();
    classic(1, MW - 1, 4'hf, 32'h5A5A_0001, 0, "err_preload");
    classic(1, MW, 4'hf, 32'hFFFF_FFFF, 1, "err_write");
    classic(0, MW, 4'hf, 0, 1, "err_read");
    classic(0, MW - 1, 4'hf, 0, 0, "err_unchanged");
    classic(1, MW - 2, 4'hf, 32'h5A5A_0002, 0, "err_preload2");
    burst(0, MW - 2, 4, 2'b00, -1, -1, "burst_err");
  endtask

  task automatic test_abort();
    logic a, e;
    int n;
    logic [31:0] d;
    // cyc dropped after two write beats: the third word must keep its old value
    for (int b = 0; b < 2; b++) begin
      @(posedge clk_i); #1;
      d = $urandom();
      bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.sel = 4'hf; bus.wdat = d;
      bus.adr = addr_of(100 + b); bus.cti = 3'b010; bus.bte = 2'b00;
      wait_term(a, e, n);
      checks++;
      if (a !== 1'b1 || n != (b == 0 ? 2 : 1)) begin
        errors++; $display("FAIL cyc_drop beat %0d ack %b latency %0d", b, a, n);
      end
      if (a === 1'b1) model_write(100 + b, d, 4'hf);
    end
    @(posedge clk_i); #1;
    bus.adr = addr_of(102); bus.wdat = ~model[102]; bus.cyc = 0; bus.stb = 0;
    @(negedge clk_i);
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++; $display("FAIL cyc_drop ack got %b expected 0", bus.ack);
    end
    idle_bus();
    classic(0, 102, 4'hf, 0, 0, "cyc_drop_nowrite");
    classic(0, 101, 4'hf, 0, 0, "cyc_drop_done");

    // reset asserted while a write beat is being acknowledged
    @(posedge clk_i); #1;
    d = $urandom();
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.sel = 4'hf; bus.wdat = d;
    bus.adr = addr_of(110); bus.cti = 3'b010; bus.bte = 2'b00;
    wait_term(a, e, n);
    if (a === 1'b1) model_write(110, d, 4'hf);
    @(posedge clk_i); #1;
    bus.adr = addr_of(111); bus.wdat = ~model[111];
    @(negedge clk_i);
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++; $display("FAIL rst_abort pre ack got %b expected 1", bus.ack);
    end
    #1 rst_n_i = 0;
    #1;
    checks++;
    if ({bus.ack, bus.err} !== 2'b00 || bus.rdat !== 32'h0) begin
      errors++; $display("FAIL rst_abort ack/err %b%b rdata %h expected 00 0", bus.ack, bus.err, bus.rdat);
    end
    repeat (2) @(posedge clk_i);
    #1;
    idle_bus();
    rst_n_i = 1;
    classic(0, 111, 4'hf, 0, 0, "rst_abort_nowrite");
    classic(0, 110, 4'hf, 0, 0, "rst_abort_done");
  endtask

  initial begin
    idle_bus();
    for (int i = 0; i < MW; i++) known[i] = 0;
    test_reset();
    test_classic();
    burst(1, 0, 256, 2'b00, -1, -1, "prefill");
    test_wrap4();
    test_master_wait();
    test_mispredict();
    test_random();
    test_error();
    classic(1, 102, 4'hf, 32'hCAFE_0102, 0, "abort_preload");
    classic(1, 111, 4'hf, 32'hCAFE_0111, 0, "abort_preload");
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
